// File: rtl/light_sequencer.sv
// light_sequencer: round-robin NUM_CH traffic-light sequencer with tick prescaler, enable and force-red.
// Define LSEQ_ACTUATED_EN for demand-driven channel selection and green extension from req.
module light_sequencer #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned PRESCALE = 500000,
  parameter int unsigned GREEN_T  = 8,
  parameter int unsigned YELLOW_T = 2,
  parameter int unsigned ALLRED_T = 1,
  localparam int unsigned CH_W    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  force_red,
  input  logic [NUM_CH-1:0]     req,
  output logic [2*NUM_CH-1:0]   light,
  output logic [CH_W-1:0]       active_ch,
  output logic [1:0]            state,
  output logic                  tick
);

  localparam int unsigned       PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned       LW        = 2 * NUM_CH;
  localparam logic [PW-1:0]     PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [7:0]        GREEN_RL  = 8'(GREEN_T - 1);
  localparam logic [7:0]        YELLOW_RL = 8'(YELLOW_T - 1);
  localparam logic [7:0]        ALLRED_RL = 8'(ALLRED_T - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_ALLRED = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10
  } state_t;

  state_t            state_q;
  logic [7:0]        dwell_q;
  logic [PW-1:0]     pre_q;
  logic              tick_q;
  logic [CH_W-1:0]   active_q;
  logic [LW-1:0]     light_q;

  logic [CH_W-1:0]   nxt_ch;
  logic [CH_W-1:0]   prv_ch;
  logic [CH_W-1:0]   go_ch;
  logic              go_ok;
  logic              extend;

  assign nxt_ch = (active_q == LAST_CH) ? '0 : active_q + 1'b1;
  assign prv_ch = (active_q == '0) ? LAST_CH : active_q - 1'b1;

`ifdef LSEQ_ACTUATED_EN
  logic [CH_W-1:0]   scan_c;
  logic [NUM_CH-1:0] others;

  // Cyclic search starting at active+1; the active channel itself is visited last.
  always_comb begin
    go_ok  = 1'b0;
    go_ch  = active_q;
    scan_c = nxt_ch;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!go_ok && req[scan_c]) begin
        go_ok = 1'b1;
        go_ch = scan_c;
      end
      scan_c = (scan_c == LAST_CH) ? '0 : scan_c + 1'b1;
    end
  end

  assign others = req & ~(NUM_CH'(1) << active_q);
  assign extend = req[active_q] && (others == '0);
`else
  logic unused_req;
  assign unused_req = ^req;
  assign go_ok      = 1'b1;
  assign go_ch      = nxt_ch;
  assign extend     = 1'b0;
`endif

  function automatic logic [LW-1:0] light_of(state_t s, logic [CH_W-1:0] ch);
    logic [1:0] code;
    code = (s == S_GREEN) ? 2'b01 : (s == S_YELLOW) ? 2'b10 : 2'b00;
    return LW'(code) << {ch, 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_ALLRED;
      dwell_q  <= ALLRED_RL;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      active_q <= LAST_CH;
      light_q  <= '0;
    end else if (force_red) begin
      state_q  <= S_ALLRED;
      dwell_q  <= ALLRED_RL;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      light_q  <= '0;
      // Step back so the interrupted channel is served again after clearance.
      if (state_q != S_ALLRED) active_q <= prv_ch;
    end else begin
      if (en) begin
        pre_q  <= (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        tick_q <= (pre_q == PRE_MAX);
      end else begin
        tick_q <= 1'b0;
      end
      if (tick_q) begin
        if (dwell_q != '0) begin
          dwell_q <= dwell_q - 1'b1;
        end else begin
          case (state_q)
            S_ALLRED: begin
              if (go_ok) begin
                state_q  <= S_GREEN;
                active_q <= go_ch;
                dwell_q  <= GREEN_RL;
                light_q  <= light_of(S_GREEN, go_ch);
              end else begin
                dwell_q  <= ALLRED_RL;
              end
            end
            S_GREEN: begin
              if (extend) begin
                dwell_q <= GREEN_RL;
              end else begin
                state_q <= S_YELLOW;
                dwell_q <= YELLOW_RL;
                light_q <= light_of(S_YELLOW, active_q);
              end
            end
            default: begin
              state_q <= S_ALLRED;
              dwell_q <= ALLRED_RL;
              light_q <= '0;
            end
          endcase
        end
      end
    end
  end

  assign light     = light_q;
  assign active_ch = active_q;
  assign state     = state_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer: expected output changes are queued per phase and checked on arrival.
module tb_light_sequencer;

  logic       clk = 1'b0;
  logic       reset, en, force_red;
  logic [2:0] req;
  logic [5:0] light;
  logic [1:0] active_ch;
  logic [1:0] state;
  logic       tick;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [1:0] ch;
    logic [5:0] lt;
  } ev_t;
  ev_t exp_q[$];

  logic [9:0] snap, prev;
  ev_t        e;
  int         nz;
  logic       bad11;

  light_sequencer #(
    .NUM_CH  (3),
    .PRESCALE(4),
    .GREEN_T (3),
    .YELLOW_T(2),
    .ALLRED_T(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .force_red(force_red),
    .req      (req),
    .light    (light),
    .active_ch(active_ch),
    .state    (state),
    .tick     (tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at rel cycle %0d: observed=%0h expected=%0h", tag, cyc - base, obs, expv);
    end
  endtask

  task automatic push(int c, logic [1:0] st, logic [1:0] ch, logic [5:0] lt);
    ev_t x;
    x.cyc = c; x.st = st; x.ch = ch; x.lt = lt;
    exp_q.push_back(x);
  endtask

  task automatic wait_rel(int n);
    while ((cyc - base) < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      bad11 = 1'b0;
      nz    = 0;
      for (int i = 0; i < 3; i++) begin
        if (light[2*i +: 2] == 2'b11) bad11 = 1'b1;
        if (light[2*i +: 2] != 2'b00) nz++;
      end
      chk("no_code_11", bad11, 1'b0);
      chk("one_nonred", (nz <= 1), 1'b1);
      snap = {state, active_ch, light};
      if (snap !== prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_change", snap, prev);
        end else begin
          e = exp_q.pop_front();
          chk("ev_cycle", cyc - base, e.cyc);
          chk("ev_state", state, e.st);
          chk("ev_active_ch", active_ch, e.ch);
          chk("ev_light", light, e.lt);
        end
        prev = snap;
      end
    end
  end

  initial begin
    reset = 1'b0; en = 1'b1; force_red = 1'b0; req = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 2'b00);
    chk("rst_active_ch", active_ch, 2'd2);
    chk("rst_light", light, 6'b0);
    chk("rst_tick", tick, 1'b0);

    // Free run: three channels, 24 clocks each.
    push(5,  2'b01, 2'd0, 6'b000001);
    push(17, 2'b10, 2'd0, 6'b000010);
    push(25, 2'b00, 2'd0, 6'b000000);
    push(29, 2'b01, 2'd1, 6'b000100);
    push(41, 2'b10, 2'd1, 6'b001000);
    push(49, 2'b00, 2'd1, 6'b000000);
    push(53, 2'b01, 2'd2, 6'b010000);
    push(65, 2'b10, 2'd2, 6'b100000);
    push(73, 2'b00, 2'd2, 6'b000000);
    push(77, 2'b01, 2'd0, 6'b000001);
    base   = cyc;
    reset  = 1'b1;
    prev   = {state, active_ch, light};
    mon_on = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      wait_rel(k);
      chk("tick_startup", tick, (k % 4 == 0));
    end

    // Enable low for edges 80..89 during ch0 green: everything shifts by 10.
    wait_rel(79);
    push(99,  2'b10, 2'd0, 6'b000010);
    push(107, 2'b00, 2'd0, 6'b000000);
    push(111, 2'b01, 2'd1, 6'b000100);
    push(123, 2'b10, 2'd1, 6'b001000);
    en = 1'b0;
    for (int k = 80; k <= 89; k++) begin
      wait_rel(k);
      chk("tick_frozen", tick, 1'b0);
    end
    en = 1'b1;
    wait_rel(90);
    chk("tick_resume", tick, 1'b1);

    // Force-red at edges 125..126 during ch1 yellow.
    wait_rel(124);
    push(125, 2'b00, 2'd0, 6'b000000);
    push(131, 2'b01, 2'd1, 6'b000100);
    push(143, 2'b10, 2'd1, 6'b001000);
    push(151, 2'b00, 2'd1, 6'b000000);
    push(155, 2'b01, 2'd2, 6'b010000);
    push(167, 2'b10, 2'd2, 6'b100000);
    force_red = 1'b1;
    wait_rel(125);
    chk("tick_force", tick, 1'b0);
    wait_rel(126);
    force_red = 1'b0;
    wait_rel(130);
    chk("tick_after_force", tick, 1'b1);

    // Reset pulse at edge 170 during ch2 yellow.
    wait_rel(169);
    push(170, 2'b00, 2'd2, 6'b000000);
    push(175, 2'b01, 2'd0, 6'b000001);
    push(187, 2'b10, 2'd0, 6'b000010);
    push(195, 2'b00, 2'd0, 6'b000000);
    push(199, 2'b01, 2'd1, 6'b000100);
    reset = 1'b0;
    wait_rel(170);
    chk("tick_midreset", tick, 1'b0);
    reset = 1'b1;
    wait_rel(174);
    chk("tick_after_reset", tick, 1'b1);

`ifdef LSEQ_ACTUATED_EN
    // Only ch2 requests: ch2 served, green extends, then all-red holds.
    wait_rel(200);
    push(211, 2'b10, 2'd1, 6'b001000);
    push(219, 2'b00, 2'd1, 6'b000000);
    push(223, 2'b01, 2'd2, 6'b010000);
    push(247, 2'b10, 2'd2, 6'b100000);
    push(255, 2'b00, 2'd2, 6'b000000);
    req = 3'b100;
    wait_rel(240);
    req = 3'b000;
    wait_rel(300);
    chk("hold_state", state, 2'b00);
    chk("hold_active_ch", active_ch, 2'd2);
`else
    wait_rel(205);
`endif

    chk("events_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
